// File: rtl/axi_receive_pkg.sv
// Definitions shared by axi_transmit and axi_receive: beat-count arithmetic
// and the deserialiser state type.
package axi_receive_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Number of beats needed to carry one bus word; 1 when a beat covers the word.
  function automatic int max_beats(input int bus_width, input int data_width);
    return ceil_div(bus_width, data_width);
  endfunction

endpackage

// File: rtl/axi_receive.sv
// Deserialiser: gathers DATA_WIDTH beats LSB-first into one BUS_WIDTH word,
// presents it on a held valid/ready port and flags short/long packets.
module axi_receive
  import axi_receive_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [BUS_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_short,
  output logic                  err_long
);

  localparam int MAX_BEATS = max_beats(BUS_WIDTH, DATA_WIDTH);
  localparam int CW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PW        = MAX_BEATS * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [BUS_WIDTH-1:0] asm_r;
  logic [PW-1:0]        wide_s;
  logic                 accept_s;
  logic                 complete_s;
  logic                 short_s;
  logic                 long_s;
  logic                 unused_s;

  assign accept_s   = s_valid && s_ready;
  assign complete_s = s_last || (cnt_r == LAST_CNT);
  assign short_s    = accept_s && s_last && (cnt_r != LAST_CNT);
  assign long_s     = accept_s && !s_last && (cnt_r == LAST_CNT);
  // Bits of the final beat beyond BUS_WIDTH are intentionally dropped.
  assign unused_s   = ^wide_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: a completing beat during consumption keeps us in HOLD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      COLLECT: begin
        if (accept_s && complete_s) state_s = HOLD;
        else                        state_s = COLLECT;
      end
      HOLD: begin
        if (m_ready && !(accept_s && complete_s)) state_s = COLLECT;
        else                                      state_s = HOLD;
      end
      default: state_s = COLLECT;
    endcase
  end

  // Upstream ready: free while collecting, or when the held word leaves now.
  always_comb begin
    s_ready = 1'b0;
    case (state_r)
      COLLECT: s_ready = 1'b1;
      HOLD:    s_ready = m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  // Assembly: beat 0 starts from a cleared word so unfilled upper bits read 0.
  always_comb begin
    wide_s = '0;
    if (cnt_r != '0) wide_s[BUS_WIDTH-1:0] = asm_r;
    else             wide_s = '0;
    for (int k = 0; k < MAX_BEATS; k++) begin
      wide_s[k*DATA_WIDTH +: DATA_WIDTH] =
        (cnt_r == CW'(k)) ? s_data : wide_s[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Beat counter next value.
  always_comb begin
    cnt_s = cnt_r;
    if (accept_s) cnt_s = complete_s ? '0 : cnt_r + CW'(1);
    else          cnt_s = cnt_r;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      asm_r     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      if (accept_s) asm_r <= wide_s[BUS_WIDTH-1:0];
      if (accept_s && complete_s) m_data <= wide_s[BUS_WIDTH-1:0];
      m_valid   <= (state_s == HOLD);
      err_short <= short_s;
      err_long  <= long_s;
    end
  end

endmodule

// File: tb/tb_axi_receive.sv
// Directed and randomised-handshake bench for axi_receive over twelve
// BUS_WIDTH x DATA_WIDTH configurations sharing one clock and reset.
`timescale 1ns/1ps
module tb_axi_receive;

  localparam int NC = 12;

  function automatic int bw_of(input int c);
    case (c / 2)
      0:       return 111;
      1:       return 32;
      2:       return 16;
      3:       return 11;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int dw_of(input int c);
    return (c % 2 == 1) ? 32 : 16;
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data [NC];
  logic [NC-1:0] s_valid;
  logic [NC-1:0] s_last;
  logic [NC-1:0] m_ready;
  wire  [NC-1:0] s_ready;
  wire  [NC-1:0] m_valid;
  wire  [NC-1:0] err_short;
  wire  [NC-1:0] err_long;
  wire  [110:0]  m_data [NC];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int BW = bw_of(g);
    localparam int DW = dw_of(g);
    wire [BW-1:0] md;
    axi_receive #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data[g][DW-1:0]),
      .s_valid  (s_valid[g]),
      .s_last   (s_last[g]),
      .s_ready  (s_ready[g]),
      .m_data   (md),
      .m_valid  (m_valid[g]),
      .m_ready  (m_ready[g]),
      .err_short(err_short[g]),
      .err_long (err_long[g])
    );
    assign m_data[g] = 111'(md);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for s_ready, return one step after acceptance.
  task automatic send_beat(input int c, input logic [31:0] d, input logic last);
    int n = 0;
    s_data[c]  = d;
    s_last[c]  = last;
    s_valid[c] = 1'b1;
    #1;
    while (!s_ready[c] && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout cfg%0d: s_ready stayed 0 for %0d cycles, required 1", c, n);
    end
    @(posedge clk);
    #1;
    s_valid[c] = 1'b0;
    s_last[c]  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (m_valid[c] !== 1'b0 || m_data[c] !== 111'd0 || err_short[c] !== 1'b0 ||
          err_long[c] !== 1'b0 || s_ready[c] !== 1'b1) begin
        errors++;
        $display("FAIL reset cfg%0d: m_valid=%b m_data=%h err_short=%b err_long=%b s_ready=%b, required 0 0 0 0 1",
                 c, m_valid[c], m_data[c], err_short[c], err_long[c], s_ready[c]);
      end
    end
  endtask

  // BUS=111 DATA=16: seven beats, final beat truncated to 15 bits.
  task automatic test_full_packet();
    logic [110:0] exp_w;
    exp_w = {15'h7FFF, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
    m_ready[0] = 1'b1;
    for (int k = 0; k < 6; k++) send_beat(0, 32'h0000A000 | 32'(k), 1'b0);
    checks++;
    if (m_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_partial_valid: m_valid=%b, required 0", m_valid[0]);
    end
    send_beat(0, 32'h0000FFFF, 1'b1);
    checks++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== exp_w) begin
      errors++;
      $display("FAIL full_word: m_valid=%b m_data=%h, required 1 %h", m_valid[0], m_data[0], exp_w);
    end
    checks++;
    if (err_short[0] !== 1'b0 || err_long[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_flags: err_short=%b err_long=%b, required 0 0", err_short[0], err_long[0]);
    end
    tick();
    checks++;
    if (m_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_pulse: m_valid=%b, required 0", m_valid[0]);
    end
  endtask

  // BUS=1 DATA=32: single-beat words, back to back.
  task automatic test_single_bit();
    m_ready[11] = 1'b1;
    send_beat(11, 32'hFFFFFFFF, 1'b1);
    checks++;
    if (m_valid[11] !== 1'b1 || m_data[11] !== 111'd1 || err_short[11] !== 1'b0 || err_long[11] !== 1'b0) begin
      errors++;
      $display("FAIL bit_one: m_valid=%b m_data=%h errs=%b%b, required 1 1 00",
               m_valid[11], m_data[11], err_short[11], err_long[11]);
    end
    send_beat(11, 32'h00000000, 1'b1);
    checks++;
    if (m_valid[11] !== 1'b1 || m_data[11] !== 111'd0 || err_short[11] !== 1'b0 || err_long[11] !== 1'b0) begin
      errors++;
      $display("FAIL bit_zero: m_valid=%b m_data=%h errs=%b%b, required 1 0 00",
               m_valid[11], m_data[11], err_short[11], err_long[11]);
    end
    tick();
    checks++;
    if (m_valid[11] !== 1'b0) begin
      errors++;
      $display("FAIL bit_drain: m_valid=%b, required 0", m_valid[11]);
    end
  endtask

  // BUS=32 DATA=16: held word under backpressure, then consume + accept together.
  task automatic test_backpressure();
    m_ready[2] = 1'b0;
    send_beat(2, 32'h00001234, 1'b0);
    send_beat(2, 32'h00005678, 1'b1);
    s_data[2]  = 32'h0000BEEF;
    s_last[2]  = 1'b0;
    s_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (m_valid[2] !== 1'b1 || m_data[2] !== 111'h56781234 || s_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: m_valid=%b m_data=%h s_ready=%b, required 1 56781234 0",
                 i, m_valid[2], m_data[2], s_ready[2]);
      end
      tick();
    end
    m_ready[2] = 1'b1;
    #1;
    checks++;
    if (s_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: s_ready=%b, required 1", s_ready[2]);
    end
    tick();
    s_valid[2] = 1'b0;
    checks++;
    if (m_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL release_consume: m_valid=%b, required 0", m_valid[2]);
    end
    send_beat(2, 32'h0000CAFE, 1'b1);
    checks++;
    if (m_valid[2] !== 1'b1 || m_data[2] !== 111'hCAFEBEEF) begin
      errors++;
      $display("FAIL beef_word: m_valid=%b m_data=%h, required 1 cafebeef", m_valid[2], m_data[2]);
    end
    tick();
  endtask

  // BUS=111 DATA=32: last on beat 1 of 4.
  task automatic test_err_short();
    logic [110:0] exp_w;
    exp_w = {47'd0, 32'h12345678, 32'hA5A5A5A5};
    m_ready[1] = 1'b1;
    send_beat(1, 32'hA5A5A5A5, 1'b0);
    send_beat(1, 32'h12345678, 1'b1);
    checks++;
    if (m_valid[1] !== 1'b1 || m_data[1] !== exp_w || err_short[1] !== 1'b1 || err_long[1] !== 1'b0) begin
      errors++;
      $display("FAIL short_word: m_valid=%b m_data=%h err_short=%b err_long=%b, required 1 %h 1 0",
               m_valid[1], m_data[1], err_short[1], err_long[1], exp_w);
    end
    tick();
    checks++;
    if (err_short[1] !== 1'b0 || m_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: err_short=%b m_valid=%b, required 0 0", err_short[1], m_valid[1]);
    end
  endtask

  // BUS=32 DATA=16: two beats with no last, next beat starts a fresh word.
  task automatic test_err_long();
    m_ready[2] = 1'b1;
    send_beat(2, 32'h00001111, 1'b0);
    send_beat(2, 32'h00002222, 1'b0);
    checks++;
    if (m_valid[2] !== 1'b1 || m_data[2] !== 111'h22221111 || err_long[2] !== 1'b1 || err_short[2] !== 1'b0) begin
      errors++;
      $display("FAIL long_word: m_valid=%b m_data=%h err_long=%b err_short=%b, required 1 22221111 1 0",
               m_valid[2], m_data[2], err_long[2], err_short[2]);
    end
    send_beat(2, 32'h00003333, 1'b0);
    checks++;
    if (m_valid[2] !== 1'b0 || err_long[2] !== 1'b0) begin
      errors++;
      $display("FAIL long_pulse: m_valid=%b err_long=%b, required 0 0", m_valid[2], err_long[2]);
    end
    send_beat(2, 32'h00004444, 1'b1);
    checks++;
    if (m_valid[2] !== 1'b1 || m_data[2] !== 111'h44443333 || err_long[2] !== 1'b0 || err_short[2] !== 1'b0) begin
      errors++;
      $display("FAIL long_next: m_valid=%b m_data=%h errs=%b%b, required 1 44443333 00",
               m_valid[2], m_data[2], err_short[2], err_long[2]);
    end
    tick();
  endtask

  // Reset mid-packet and while holding a word.
  task automatic test_reset_mid();
    logic [110:0] exp_w;
    exp_w = {15'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100};
    m_ready[0] = 1'b1;
    send_beat(0, 32'h00001111, 1'b0);
    send_beat(0, 32'h00002222, 1'b0);
    send_beat(0, 32'h00003333, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid[0] !== 1'b0 || err_short[0] !== 1'b0 || err_long[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: m_valid=%b errs=%b%b s_ready=%b, required 0 00 1",
               m_valid[0], err_short[0], err_long[0], s_ready[0]);
    end
    for (int k = 0; k < 6; k++) send_beat(0, 32'h00000100 | 32'(k), 1'b0);
    send_beat(0, 32'h00000106, 1'b1);
    checks++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== exp_w || err_short[0] !== 1'b0 || err_long[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_clean_word: m_valid=%b m_data=%h errs=%b%b, required 1 %h 00",
               m_valid[0], m_data[0], err_short[0], err_long[0], exp_w);
    end
    tick();
    m_ready[2] = 1'b0;
    send_beat(2, 32'h000000AA, 1'b0);
    send_beat(2, 32'h000000BB, 1'b1);
    checks++;
    if (m_valid[2] !== 1'b1 || m_data[2] !== 111'h00BB00AA) begin
      errors++;
      $display("FAIL hold_before_rst: m_valid=%b m_data=%h, required 1 00bb00aa", m_valid[2], m_data[2]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid[2] !== 1'b0 || m_data[2] !== 111'd0 || s_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold: m_valid=%b m_data=%h s_ready=%b, required 0 0 1", m_valid[2], m_data[2], s_ready[2]);
    end
    m_ready[2] = 1'b1;
  endtask

  // Random 50% s_valid / m_ready over 20 full-length words per configuration.
  task automatic test_random(input int c);
    int           bw  = bw_of(c);
    int           dw  = dw_of(c);
    int           mb  = (bw + dw - 1) / dw;
    int           got = 0;
    int           cyc = 0;
    logic         acc;
    logic         err_seen = 1'b0;
    logic [31:0]  b;
    logic [110:0] w;
    logic [31:0]  bq [$];
    logic         lq [$];
    logic [110:0] wq [$];
    for (int i = 0; i < 20; i++) begin
      w = '0;
      for (int k = 0; k < mb; k++) begin
        b = $urandom;
        bq.push_back(b);
        lq.push_back(k == mb - 1);
        for (int j = 0; j < dw; j++) if (k * dw + j < bw) w[k*dw+j] = b[j];
      end
      wq.push_back(w);
    end
    s_valid[c] = 1'b0;
    while (got < 20 && cyc < 5000) begin
      if (!s_valid[c] && bq.size() > 0 && $urandom_range(1, 0) == 1) begin
        s_data[c]  = bq.pop_front();
        s_last[c]  = lq.pop_front();
        s_valid[c] = 1'b1;
      end
      m_ready[c] = ($urandom_range(1, 0) == 1);
      #1;
      acc = s_valid[c] && s_ready[c];
      err_seen = err_seen | err_short[c] | err_long[c];
      if (m_valid[c] && m_ready[c]) begin
        checks++;
        if (m_data[c] !== wq[got]) begin
          errors++;
          $display("FAIL rand_cfg%0d_word%0d: m_data=%h, required %h", c, got, m_data[c], wq[got]);
        end
        got++;
      end
      tick();
      cyc++;
      if (acc) s_valid[c] = 1'b0;
    end
    s_valid[c] = 1'b0;
    m_ready[c] = 1'b1;
    checks++;
    if (got !== 20) begin
      errors++;
      $display("FAIL rand_cfg%0d_count: words=%0d, required 20", c, got);
    end
    checks++;
    if (err_seen !== 1'b0) begin
      errors++;
      $display("FAIL rand_cfg%0d_flags: error flag seen=%b, required 0", c, err_seen);
    end
    tick();
  endtask

  initial begin
    s_valid = '0;
    s_last  = '0;
    m_ready = '0;
    for (int c = 0; c < NC; c++) s_data[c] = '0;
    test_reset();
    test_full_packet();
    test_single_bit();
    test_backpressure();
    test_err_short();
    test_err_long();
    test_reset_mid();
    for (int c = 0; c < NC; c++) test_random(c);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
